// File: rtl/sum_seq_pkg.sv
// Shared types, ASCII constants and message length for the sum-latch sequencer.
// Define SUMSEQ_CRLF_EN to append CR/LF after the two hex digits.
package sum_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_STROBE_A = 3'd1,
    S_STROBE_B = 3'd2,
    S_CAPTURE  = 3'd3,
    S_SEND     = 3'd4
  } seq_state_t;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_A_OFS = 8'h37;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

`ifdef SUMSEQ_CRLF_EN
  localparam int unsigned MSG_LEN = 4;
`else
  localparam int unsigned MSG_LEN = 2;
`endif

  localparam logic [1:0] LAST_IDX = 2'(MSG_LEN - 1);

  function automatic logic [7:0] nib2hex(input logic [3:0] nib);
    logic [7:0] w_byte;
    if (nib < 4'd10) begin
      w_byte = ASCII_0 + {4'd0, nib};
    end else begin
      w_byte = ASCII_A_OFS + {4'd0, nib};
    end
    return w_byte;
  endfunction

endpackage

// File: rtl/sum_latch_sequencer_rise.sv
// Rising-edge detector for an already-synchronous level input.
module rise_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic pulse
);

  logic r_prev;

  // previous-cycle sample of d
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= d;
    end
  end

  assign pulse = d & ~r_prev;

endmodule

// File: rtl/sum_latch_sequencer.sv
// Sequences latch save strobes, sum capture and ASCII-hex transmission of the sum.
// Define SUMSEQ_CRLF_EN to append CR/LF to every message.
module sum_latch_sequencer
  import sum_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       req_send,
  input  logic [3:0] q_a,
  input  logic [3:0] q_b,
  output logic       save_a_n,
  output logic       save_b_n,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [4:0] sum_out,
  output logic       busy
);

  seq_state_t r_state;
  seq_state_t w_next;
  logic       w_rise_a, w_rise_b, w_rise_s;
  logic       r_pend_a, r_pend_b, r_pend_s;
  logic       w_pend_a, w_pend_b, w_pend_s;
  logic       w_clr_a, w_clr_b, w_clr_s;
  logic       r_save_a_n, r_save_b_n;
  logic [4:0] r_sum;
  logic [1:0] r_byte_idx;
  logic [7:0] w_tx_data;

  rise_detect u_rise_a (.clk(clk), .reset_n(reset_n), .d(req_a),    .pulse(w_rise_a));
  rise_detect u_rise_b (.clk(clk), .reset_n(reset_n), .d(req_b),    .pulse(w_rise_b));
  rise_detect u_rise_s (.clk(clk), .reset_n(reset_n), .d(req_send), .pulse(w_rise_s));

  // a same-cycle edge counts as pending so an idle FSM reacts without delay
  assign w_pend_a = r_pend_a | w_rise_a;
  assign w_pend_b = r_pend_b | w_rise_b;
  assign w_pend_s = r_pend_s | w_rise_s;

  // state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state logic with fixed A, B, send priority
  always_comb begin
    w_next  = r_state;
    w_clr_a = 1'b0;
    w_clr_b = 1'b0;
    w_clr_s = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pend_a) begin
          w_next  = S_STROBE_A;
          w_clr_a = 1'b1;
        end else if (w_pend_b) begin
          w_next  = S_STROBE_B;
          w_clr_b = 1'b1;
        end else if (w_pend_s) begin
          w_next  = S_CAPTURE;
          w_clr_s = 1'b1;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_STROBE_A: w_next = S_IDLE;
      S_STROBE_B: w_next = S_IDLE;
      S_CAPTURE:  w_next = S_SEND;
      S_SEND: begin
        if (tx_ready && (r_byte_idx == LAST_IDX)) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_SEND;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // sticky request flags and registered save strobes
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pend_a   <= 1'b0;
      r_pend_b   <= 1'b0;
      r_pend_s   <= 1'b0;
      r_save_a_n <= 1'b1;
      r_save_b_n <= 1'b1;
    end else begin
      r_pend_a   <= w_pend_a & ~w_clr_a;
      r_pend_b   <= w_pend_b & ~w_clr_b;
      r_pend_s   <= w_pend_s & ~w_clr_s;
      r_save_a_n <= (w_next != S_STROBE_A);
      r_save_b_n <= (w_next != S_STROBE_B);
    end
  end

  // sum snapshot and message byte index
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sum      <= 5'd0;
      r_byte_idx <= 2'd0;
    end else begin
      case (r_state)
        S_CAPTURE: begin
          r_sum      <= {1'b0, q_a} + {1'b0, q_b};
          r_byte_idx <= 2'd0;
        end
        S_SEND: begin
          if (tx_ready && (r_byte_idx != LAST_IDX)) begin
            r_byte_idx <= r_byte_idx + 2'd1;
          end else begin
            r_byte_idx <= r_byte_idx;
          end
        end
        default: begin
          r_sum      <= r_sum;
          r_byte_idx <= r_byte_idx;
        end
      endcase
    end
  end

  // message byte selection; only decoded from registers, so it holds during stalls
  always_comb begin
    w_tx_data = 8'h00;
    if (r_state == S_SEND) begin
      case (r_byte_idx)
        2'd0:    w_tx_data = nib2hex({3'b000, r_sum[4]});
        2'd1:    w_tx_data = nib2hex(r_sum[3:0]);
`ifdef SUMSEQ_CRLF_EN
        2'd2:    w_tx_data = ASCII_CR;
        2'd3:    w_tx_data = ASCII_LF;
`endif
        default: w_tx_data = 8'h00;
      endcase
    end else begin
      w_tx_data = 8'h00;
    end
  end

  assign save_a_n = r_save_a_n;
  assign save_b_n = r_save_b_n;
  assign tx_data  = w_tx_data;
  assign tx_valid = (r_state == S_SEND);
  assign sum_out  = r_sum;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_sum_latch_sequencer.sv
// Directed self-checking bench for sum_latch_sequencer (default or SUMSEQ_CRLF_EN build).
module tb_sum_latch_sequencer;

`ifdef SUMSEQ_CRLF_EN
  localparam int EXP_LEN = 4;
`else
  localparam int EXP_LEN = 2;
`endif

  logic       clk = 1'b0;
  logic       reset_n, req_a, req_b, req_send, tx_ready;
  logic [3:0] q_a, q_b;
  logic       save_a_n, save_b_n, tx_valid, busy;
  logic [7:0] tx_data;
  logic [4:0] sum_out;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_b[4];
  bit         rx_timeout;

  sum_latch_sequencer dut (
    .clk(clk), .reset_n(reset_n), .req_a(req_a), .req_b(req_b), .req_send(req_send),
    .q_a(q_a), .q_b(q_b), .save_a_n(save_a_n), .save_b_n(save_b_n),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .sum_out(sum_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // gather handshaken bytes until the FSM returns to idle, within a cycle budget
  task automatic collect(input int max_cycles);
    rx_q.delete();
    rx_timeout = 1'b1;
    for (int i = 0; i < max_cycles; i++) begin
      if (tx_valid && tx_ready) rx_q.push_back(tx_data);
      step();
      if (!busy) begin
        rx_timeout = 1'b0;
        break;
      end
    end
  endtask

  // stimulus only: load A, load B, then request a send; returns in the CAPTURE cycle
  task automatic load_and_send(input logic [3:0] qa, input logic [3:0] qb);
    q_a = qa; req_a = 1'b1; step(); req_a = 1'b0; step();
    q_b = qb; req_b = 1'b1; step(); req_b = 1'b0; step();
    req_send = 1'b1; step(); req_send = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) step();
    n_checks++; if (save_a_n !== 1'b1) begin n_fail++; $display("FAIL rst_save_a_n: got %b expected 1", save_a_n); end
    n_checks++; if (save_b_n !== 1'b1) begin n_fail++; $display("FAIL rst_save_b_n: got %b expected 1", save_b_n); end
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_tx_valid: got %b expected 0", tx_valid); end
    n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_tx_data: got %h expected 00", tx_data); end
    n_checks++; if (sum_out !== 5'd0) begin n_fail++; $display("FAIL rst_sum_out: got %0d expected 0", sum_out); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
    reset_n = 1'b1;
    n_checks++; if (busy !== 1'b0 || save_a_n !== 1'b1) begin n_fail++; $display("FAIL rel_idle: got busy=%b save_a_n=%b expected 0/1", busy, save_a_n); end
    step();
    n_checks++; if (save_a_n !== 1'b0 || save_b_n !== 1'b1) begin n_fail++; $display("FAIL rel_strobe_a: got %b%b expected 01", save_a_n, save_b_n); end
    step();
    n_checks++; if (save_a_n !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rel_after_a: got save_a_n=%b busy=%b expected 1/0", save_a_n, busy); end
    step();
    n_checks++; if (save_b_n !== 1'b0 || save_a_n !== 1'b1) begin n_fail++; $display("FAIL rel_strobe_b: got %b%b expected 10", save_a_n, save_b_n); end
    step(); step();
    n_checks++; if (tx_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL rel_capture: got valid=%b busy=%b expected 0/1", tx_valid, busy); end
    step();
    n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h30) begin n_fail++; $display("FAIL rel_send_start: got valid=%b data=%h expected 1/30", tx_valid, tx_data); end
    req_a = 1'b0; req_b = 1'b0; req_send = 1'b0;
    collect(20);
    exp_b[0] = 8'h30; exp_b[1] = 8'h30; exp_b[2] = 8'h0D; exp_b[3] = 8'h0A;
    n_checks++; if (rx_timeout || rx_q.size() != EXP_LEN) begin n_fail++; $display("FAIL rst_msg_len: got %0d bytes (timeout=%b) expected %0d", rx_q.size(), rx_timeout, EXP_LEN); end
    for (int k = 0; k < EXP_LEN; k++) begin
      n_checks++;
      if (k >= rx_q.size() || rx_q[k] !== exp_b[k]) begin n_fail++; $display("FAIL rst_msg_byte%0d: got %h expected %h", k, (k < rx_q.size()) ? rx_q[k] : 8'hxx, exp_b[k]); end
    end
  endtask

  task automatic test_sum_9_7();
    tx_ready = 1'b1;
    load_and_send(4'h9, 4'h7);
    collect(20);
    exp_b[0] = 8'h31; exp_b[1] = 8'h30; exp_b[2] = 8'h0D; exp_b[3] = 8'h0A;
    n_checks++; if (rx_timeout || rx_q.size() != EXP_LEN) begin n_fail++; $display("FAIL s97_msg_len: got %0d bytes (timeout=%b) expected %0d", rx_q.size(), rx_timeout, EXP_LEN); end
    for (int k = 0; k < EXP_LEN; k++) begin
      n_checks++;
      if (k >= rx_q.size() || rx_q[k] !== exp_b[k]) begin n_fail++; $display("FAIL s97_msg_byte%0d: got %h expected %h", k, (k < rx_q.size()) ? rx_q[k] : 8'hxx, exp_b[k]); end
    end
    n_checks++; if (sum_out !== 5'd16) begin n_fail++; $display("FAIL s97_sum_out: got %0d expected 16", sum_out); end
  endtask

  task automatic test_sum_hex();
    load_and_send(4'hF, 4'hF);
    collect(20);
    n_checks++; if (rx_timeout || rx_q.size() != EXP_LEN) begin n_fail++; $display("FAIL sff_msg_len: got %0d bytes expected %0d", rx_q.size(), EXP_LEN); end
    n_checks++; if (rx_q.size() < 2 || rx_q[0] !== 8'h31 || rx_q[1] !== 8'h45) begin n_fail++; $display("FAIL sff_digits: got %p expected 31 45", rx_q); end
    n_checks++; if (sum_out !== 5'd30) begin n_fail++; $display("FAIL sff_sum_out: got %0d expected 30", sum_out); end
    load_and_send(4'hA, 4'h0);
    collect(20);
    n_checks++; if (rx_q.size() < 2 || rx_q[0] !== 8'h30 || rx_q[1] !== 8'h41) begin n_fail++; $display("FAIL sa0_digits: got %p expected 30 41", rx_q); end
    n_checks++; if (sum_out !== 5'd10) begin n_fail++; $display("FAIL sa0_sum_out: got %0d expected 10", sum_out); end
  endtask

  task automatic test_ready_stall();
    tx_ready = 1'b0;
    load_and_send(4'h9, 4'h7);
    step();
    for (int i = 0; i < 7; i++) begin
      n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h31) begin n_fail++; $display("FAIL stall_hold%0d: got valid=%b data=%h expected 1/31", i, tx_valid, tx_data); end
      step();
    end
    tx_ready = 1'b1;
    collect(20);
    exp_b[0] = 8'h31; exp_b[1] = 8'h30; exp_b[2] = 8'h0D; exp_b[3] = 8'h0A;
    n_checks++; if (rx_timeout || rx_q.size() != EXP_LEN) begin n_fail++; $display("FAIL stall_msg_len: got %0d bytes expected %0d", rx_q.size(), EXP_LEN); end
    for (int k = 0; k < EXP_LEN; k++) begin
      n_checks++;
      if (k >= rx_q.size() || rx_q[k] !== exp_b[k]) begin n_fail++; $display("FAIL stall_msg_byte%0d: got %h expected %h", k, (k < rx_q.size()) ? rx_q[k] : 8'hxx, exp_b[k]); end
    end
  endtask

  task automatic test_req_during_send();
    int strobe_cnt;
    int strobe_at;
    int idle_at;
    strobe_cnt = 0; strobe_at = -1; idle_at = -1;
    tx_ready = 1'b1;
    load_and_send(4'h9, 4'h7);
    step();
    rx_q.delete();
    for (int i = 0; i < 12; i++) begin
      if (tx_valid && tx_ready) rx_q.push_back(tx_data);
      if (!save_a_n) begin strobe_cnt++; strobe_at = i; end
      if (!busy && idle_at < 0) idle_at = i;
      req_a = (i == 1);
      step();
    end
    req_a = 1'b0;
    exp_b[0] = 8'h31; exp_b[1] = 8'h30; exp_b[2] = 8'h0D; exp_b[3] = 8'h0A;
    n_checks++; if (rx_q.size() != EXP_LEN) begin n_fail++; $display("FAIL rds_msg_len: got %0d bytes expected %0d", rx_q.size(), EXP_LEN); end
    for (int k = 0; k < EXP_LEN; k++) begin
      n_checks++;
      if (k >= rx_q.size() || rx_q[k] !== exp_b[k]) begin n_fail++; $display("FAIL rds_msg_byte%0d: got %h expected %h", k, (k < rx_q.size()) ? rx_q[k] : 8'hxx, exp_b[k]); end
    end
    n_checks++; if (strobe_cnt != 1) begin n_fail++; $display("FAIL rds_strobe_count: got %0d expected 1", strobe_cnt); end
    n_checks++; if (idle_at != EXP_LEN || strobe_at != EXP_LEN + 1) begin n_fail++; $display("FAIL rds_strobe_time: got idle@%0d strobe@%0d expected %0d/%0d", idle_at, strobe_at, EXP_LEN, EXP_LEN + 1); end
  endtask

  task automatic test_reset_mid_send();
    tx_ready = 1'b1;
    load_and_send(4'h9, 4'h7);
    step(); step();
    n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h30) begin n_fail++; $display("FAIL rms_at_idx1: got valid=%b data=%h expected 1/30", tx_valid, tx_data); end
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    n_checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rms_abort: got valid=%b busy=%b expected 0/0", tx_valid, busy); end
    n_checks++; if (sum_out !== 5'd0 || tx_data !== 8'h00) begin n_fail++; $display("FAIL rms_reset_vals: got sum=%0d data=%h expected 0/00", sum_out, tx_data); end
    req_send = 1'b1; step(); req_send = 1'b0;
    collect(20);
    exp_b[0] = 8'h31; exp_b[1] = 8'h30; exp_b[2] = 8'h0D; exp_b[3] = 8'h0A;
    n_checks++; if (rx_timeout || rx_q.size() != EXP_LEN) begin n_fail++; $display("FAIL rms_msg_len: got %0d bytes expected %0d", rx_q.size(), EXP_LEN); end
    for (int k = 0; k < EXP_LEN; k++) begin
      n_checks++;
      if (k >= rx_q.size() || rx_q[k] !== exp_b[k]) begin n_fail++; $display("FAIL rms_msg_byte%0d: got %h expected %h", k, (k < rx_q.size()) ? rx_q[k] : 8'hxx, exp_b[k]); end
    end
    n_checks++; if (sum_out !== 5'd16) begin n_fail++; $display("FAIL rms_sum_out: got %0d expected 16", sum_out); end
  endtask

  initial begin
    reset_n = 1'b0; req_a = 1'b1; req_b = 1'b1; req_send = 1'b1;
    q_a = 4'h0; q_b = 4'h0; tx_ready = 1'b1;
    test_reset();
    test_sum_9_7();
    test_sum_hex();
    test_ready_stall();
    test_req_during_send();
    test_reset_mid_send();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
